// File: rtl/seq_detector_scheduler.sv
// seq_detector_scheduler: round-robin sharing of one P0,P1,P2 Moore recognizer between requesters A and B
module seq_detector_scheduler #(
  parameter logic [1:0] P0 = 2'b11,
  parameter logic [1:0] P1 = 2'b01,
  parameter logic [1:0] P2 = 2'b10,
  parameter int MAX_BURST = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_a,
  input  logic [1:0] x_a,
  input  logic       req_b,
  input  logic [1:0] x_b,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic       z,
  output logic       z_src
);
  typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} st_t;
  typedef enum logic [1:0] {S0, S1, S2, S3} rec_t;
  localparam logic [7:0] MAX = 8'(MAX_BURST);
  st_t state, state_n;
  rec_t rec, rec_n;
  logic [7:0] cnt, cnt_n;
  logic [1:0] x;
  logic last, sample, hit, entry;
  assign gnt_a = state == GNT_A;
  assign gnt_b = state == GNT_B;
  always_comb begin
    sample = (gnt_a && req_a) || (gnt_b && req_b);
    x = gnt_b ? x_b : x_a;
    cnt_n = (cnt == MAX) ? cnt : cnt + 8'd1;
    rec_n = !sample ? ((rec == S3) ? S0 : rec) :
            (rec == S1 && x == P1) ? S2 :
            (rec == S2 && x == P2) ? S3 :
            (x == P0) ? S1 : S0;
    hit = sample && rec_n == S3;
    state_n = state;
    case (state)
      IDLE:    state_n = (req_a && req_b) ? (last ? GNT_A : GNT_B) : req_a ? GNT_A : req_b ? GNT_B : IDLE;
      GNT_A:   state_n = !req_a ? IDLE : (cnt_n == MAX && req_b) ? GNT_B : GNT_A;
      GNT_B:   state_n = !req_b ? IDLE : (cnt_n == MAX && req_a) ? GNT_A : GNT_B;
      default: state_n = IDLE;
    endcase
    entry = state_n != state && state_n != IDLE;
  end
  // last: 1 means B was granted most recently, so A wins the first tie after reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      rec <= S0;
      cnt <= '0;
      last <= 1'b1;
      z <= 1'b0;
      z_src <= 1'b0;
    end else begin
      state <= state_n;
      z <= hit;
      if (hit) z_src <= gnt_b;
      if (entry) begin
        cnt <= '0;
        rec <= S0;
        last <= state_n == GNT_B;
      end else begin
        rec <= rec_n;
        if (sample) cnt <= cnt_n;
      end
    end
  end
endmodule

// File: tb/tb_seq_detector_scheduler.sv
// tb_seq_detector_scheduler: directed steps with a queue of expected detection events
module tb_seq_detector_scheduler;
  logic clock = 1'b0, reset = 1'b1, req_a = 1'b0, req_b = 1'b0;
  logic [1:0] x_a = 2'b00, x_b = 2'b00;
  logic gnt_a, gnt_b, z, z_src;
  int total = 0, bad = 0, cyc = 0;
  typedef struct {int cyc; logic src;} ev_t;
  ev_t q[$];

  seq_detector_scheduler #(.MAX_BURST(4)) dut (
    .clock(clock), .reset(reset), .req_a(req_a), .x_a(x_a), .req_b(req_b), .x_b(x_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .z(z), .z_src(z_src)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    chk("gnt_exclusive", 32'(gnt_a & gnt_b), 0);
    if (q.size() > 0 && q[0].cyc == cyc) begin
      chk("z_pulse", 32'(z), 1);
      chk("z_src", 32'(z_src), 32'(q[0].src));
      void'(q.pop_front());
    end else chk("z_quiet", 32'(z), 0);
  end

  task automatic step(input logic ra, input logic [1:0] xa, input logic rb, input logic [1:0] xb,
                      input logic ez, input logic es, input logic ga, input logic gb);
    req_a = ra; x_a = xa; req_b = rb; x_b = xb;
    if (ez) q.push_back('{cyc + 1, es});
    @(negedge clock);
    chk("gnt_a", 32'(gnt_a), 32'(ga));
    chk("gnt_b", 32'(gnt_b), 32'(gb));
  endtask

  task automatic mid_reset(input string tag);
    #2 reset = 1'b1;
    #1 chk({tag, "_gnt_b"}, 32'(gnt_b), 0);
    chk({tag, "_z"}, 32'(z), 0);
    chk({tag, "_z_src"}, 32'(z_src), 0);
    @(negedge clock) reset = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clock);
    chk("rst_gnt_a", 32'(gnt_a), 0);
    chk("rst_gnt_b", 32'(gnt_b), 0);
    chk("rst_z", 32'(z), 0);
    chk("rst_z_src", 32'(z_src), 0);
    reset = 1'b0;
    // basic detection by A
    step(1, 2'b00, 0, 2'b00, 0, 0, 1, 0);
    step(1, 2'b11, 0, 2'b00, 0, 0, 1, 0);
    step(1, 2'b01, 0, 2'b00, 0, 0, 1, 0);
    step(1, 2'b10, 0, 2'b00, 1, 0, 1, 0);
    step(0, 2'b00, 0, 2'b00, 0, 0, 0, 0);
    // overlapping prefix restart, single detection
    step(1, 2'b00, 0, 2'b00, 0, 0, 1, 0);
    step(1, 2'b11, 0, 2'b00, 0, 0, 1, 0);
    step(1, 2'b11, 0, 2'b00, 0, 0, 1, 0);
    step(1, 2'b01, 0, 2'b00, 0, 0, 1, 0);
    step(1, 2'b10, 0, 2'b00, 1, 0, 1, 0);
    step(1, 2'b01, 0, 2'b00, 0, 0, 1, 0);
    step(1, 2'b10, 0, 2'b00, 0, 0, 1, 0);
    step(0, 2'b00, 0, 2'b00, 0, 0, 0, 0);
    // fresh reset so A wins the tie, then forced switches every 4 samples
    reset = 1'b1;
    @(negedge clock) reset = 1'b0;
    step(1, 2'b00, 1, 2'b00, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 2'b00, 1, 2'b00, 0, 0, 1, 0);
    step(1, 2'b00, 1, 2'b00, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 2'b00, 1, 2'b00, 0, 0, 0, 1);
    step(1, 2'b00, 1, 2'b00, 0, 0, 1, 0);
    // A's partial pattern is not completed by B; B's detection on its final burst symbol
    step(1, 2'b00, 1, 2'b00, 0, 0, 1, 0);
    step(1, 2'b00, 1, 2'b00, 0, 0, 1, 0);
    step(1, 2'b11, 1, 2'b00, 0, 0, 1, 0);
    step(1, 2'b01, 1, 2'b00, 0, 0, 0, 1);
    step(1, 2'b00, 1, 2'b10, 0, 0, 0, 1);
    step(1, 2'b00, 1, 2'b11, 0, 0, 0, 1);
    step(1, 2'b00, 1, 2'b01, 0, 0, 0, 1);
    step(1, 2'b00, 1, 2'b10, 1, 1, 1, 0);
    step(0, 2'b00, 0, 2'b00, 0, 0, 0, 0);
    // release and re-grant clears the recognizer
    step(1, 2'b00, 0, 2'b00, 0, 0, 1, 0);
    step(1, 2'b11, 0, 2'b00, 0, 0, 1, 0);
    step(1, 2'b01, 0, 2'b00, 0, 0, 1, 0);
    step(0, 2'b10, 0, 2'b00, 0, 0, 0, 0);
    step(1, 2'b10, 0, 2'b00, 0, 0, 1, 0);
    step(1, 2'b10, 0, 2'b00, 0, 0, 1, 0);
    step(0, 2'b00, 0, 2'b00, 0, 0, 0, 0);
    chk("z_src_hold", 32'(z_src), 1);
    // asynchronous reset while z is high, then mid-pattern
    step(0, 2'b00, 1, 2'b00, 0, 0, 0, 1);
    step(0, 2'b00, 1, 2'b11, 0, 0, 0, 1);
    step(0, 2'b00, 1, 2'b01, 0, 0, 0, 1);
    step(0, 2'b00, 1, 2'b10, 1, 1, 0, 1);
    mid_reset("rst_on_z");
    step(0, 2'b00, 1, 2'b00, 0, 0, 0, 1);
    step(0, 2'b00, 1, 2'b11, 0, 0, 0, 1);
    step(0, 2'b00, 1, 2'b01, 0, 0, 0, 1);
    mid_reset("rst_mid");
    step(0, 2'b00, 1, 2'b00, 0, 0, 0, 1);
    step(0, 2'b00, 1, 2'b10, 0, 0, 0, 1);
    step(0, 2'b00, 1, 2'b11, 0, 0, 0, 1);
    step(0, 2'b00, 1, 2'b01, 0, 0, 0, 1);
    step(0, 2'b00, 1, 2'b10, 1, 1, 0, 1);
    step(0, 2'b00, 0, 2'b00, 0, 0, 0, 0);
    repeat (3) @(negedge clock);
    chk("events_pending", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
